ctrl_seq_decoder: RTL

CTRL_SEQ_DECODER -- requirements
Module: ctrl_seq_decoder

---
 rtl/ctrl_seq_decoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ctrl_seq_decoder.sv
// Watches multicycle control-unit strobes and reconstructs each retired instruction:
// opcode/funk class, cycle count (fetch included) and an error flag, one pulse per retirement.
module ctrl_seq_decoder (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        RegDest,
    input  logic        BranchCond,
    input  logic        OutputWrite,
    input  logic        MemSrc,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  SrcB,
    input  logic [1:0]  PCSrc,
    input  logic [1:0]  MemtoReg,
    input  logic        SrcA,
    output logic        dec_valid,
    output logic [3:0]  dec_opcode,
    output logic [2:0]  dec_funk,
    output logic [3:0]  dec_cycles,
    output logic        dec_err,
    output logic [15:0] retired_count
);

    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    localparam int C_SW  = 0;
    localparam int C_LW  = 1;
    localparam int C_R   = 2;
    localparam int C_IMM = 3;
    localparam int C_IN  = 4;
    localparam int C_OUT = 5;
    localparam int C_BEQ = 6;
    localparam int C_BNE = 7;
    localparam int C_JR  = 8;
    localparam int C_J   = 9;
    localparam int NCLS  = 10;

    // {opcode, funk} per one-hot class position
    localparam logic [6:0] CLS_CODE [NCLS] = '{
        7'b0011_000, 7'b0010_000, 7'b0000_000, 7'b0001_000, 7'b1100_000,
        7'b1100_001, 7'b0111_000, 7'b1000_000, 7'b1011_000, 7'b1001_000
    };

    state_t             r_state;
    state_t             w_state_next;
    logic [NCLS-1:0]    r_class_oh;
    logic               r_has_class;
    logic               r_conflict;
    logic               r_link;
    logic [3:0]         r_cycles;
    logic               r_dec_valid;
    logic [3:0]         r_dec_opcode;
    logic [2:0]         r_dec_funk;
    logic [3:0]         r_dec_cycles;
    logic               r_dec_err;
    logic [15:0]        r_retired_count;

    logic [NCLS-1:0]    w_ev;
    logic               w_any;
    logic               w_multi;
    logic               w_diff;
    logic               w_link;
    logic               w_start;
    logic               w_retire;
    logic               w_collect;
    logic [6:0]         w_code;
    logic               w_ret_err;
    logic [3:0]         w_ret_opcode;
    logic [2:0]         w_ret_funk;
    logic               w_unused;

    // Intermediate datapath selects carry no class information.
    assign w_unused = &{1'b0, MemRead, SrcA, SrcB, MemSrc};

    always_comb begin
        w_ev        = '0;
        w_ev[C_SW]  = MemWrite;
        w_ev[C_LW]  = RegWrite && (MemtoReg == 2'b01);
        w_ev[C_R]   = RegWrite && (MemtoReg == 2'b00) && RegDest;
        w_ev[C_IMM] = RegWrite && (MemtoReg == 2'b00) && !RegDest;
        w_ev[C_IN]  = RegWrite && (MemtoReg == 2'b11);
        w_ev[C_OUT] = OutputWrite;
        w_ev[C_BEQ] = BranchCond && (ALUOp == 2'b01);
        w_ev[C_BNE] = BranchCond && (ALUOp == 2'b11);
        w_ev[C_JR]  = PCWrite && (PCSrc == 2'b11);
        w_ev[C_J]   = PCWrite && (PCSrc == 2'b10);
    end

    // Link write is only an upgrade marker for j, never a class of its own.
    assign w_link  = RegWrite && (MemtoReg == 2'b10);
    assign w_any   = |w_ev;
    assign w_multi = |(w_ev & (w_ev - NCLS'(1)));
    assign w_diff  = r_has_class && w_any && (w_ev != r_class_oh);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (IRWrite) w_state_next = S_EXEC;
    end

    always_comb begin
        w_start   = IRWrite;
        w_retire  = IRWrite && (r_state == S_EXEC);
        w_collect = !IRWrite && (r_state == S_EXEC);
    end

    always_comb begin
        w_code = '0;
        for (int i = 0; i < NCLS; i++) begin
            if (r_class_oh[i]) w_code = w_code | CLS_CODE[i];
        end
    end

    always_comb begin
        w_ret_err    = !r_has_class || r_conflict;
        w_ret_opcode = w_code[6:3];
        w_ret_funk   = w_code[2:0];
        if (w_ret_err) begin
            w_ret_opcode = 4'b1111;
            w_ret_funk   = 3'b000;
        end else if (r_class_oh[C_J] && r_link) begin
            w_ret_opcode = 4'b1010;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_class_oh  <= '0;
            r_has_class <= 1'b0;
            r_conflict  <= 1'b0;
            r_link      <= 1'b0;
            r_cycles    <= 4'd0;
        end else if (w_start) begin
            r_class_oh  <= '0;
            r_has_class <= 1'b0;
            r_conflict  <= 1'b0;
            r_link      <= 1'b0;
            r_cycles    <= 4'd1;
        end else if (w_collect) begin
            if (r_cycles != 4'd15) r_cycles <= r_cycles + 4'd1;
            if (w_link) r_link <= 1'b1;
            if (w_any && !r_has_class) begin
                r_has_class <= 1'b1;
                r_class_oh  <= w_ev;
            end
            if (w_multi || w_diff) r_conflict <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dec_valid     <= 1'b0;
            r_dec_opcode    <= 4'd0;
            r_dec_funk      <= 3'd0;
            r_dec_cycles    <= 4'd0;
            r_dec_err       <= 1'b0;
            r_retired_count <= 16'd0;
        end else begin
            r_dec_valid <= w_retire;
            if (w_retire) begin
                r_dec_opcode    <= w_ret_opcode;
                r_dec_funk      <= w_ret_funk;
                r_dec_cycles    <= r_cycles;
                r_dec_err       <= w_ret_err;
                r_retired_count <= r_retired_count + 16'd1;
            end
        end
    end

    assign dec_valid     = r_dec_valid;
    assign dec_opcode    = r_dec_opcode;
    assign dec_funk      = r_dec_funk;
    assign dec_cycles    = r_dec_cycles;
    assign dec_err       = r_dec_err;
    assign retired_count = r_retired_count;

endmodule
